// File: rtl/chess_pkg.sv
// Shared definitions for the move-generator host sequencer: core command
// addresses, result-byte bit positions, command kinds and sequencer states.
package chess_pkg;

   localparam logic [7:0] CMD_NOP         = 8'h00;
   localparam logic [7:0] CMD_EN_FRIENDLY = 8'h80;
   localparam logic [7:0] CMD_FLIP        = 8'h90;
   localparam logic [7:0] CMD_ROTATE      = 8'hA0;
   localparam logic [7:0] CMD_EN_ALL      = 8'hC0;
   localparam logic [7:0] CMD_SET_EN      = 8'hD0;
   localparam logic [7:0] CMD_FIND_VIC    = 8'hE0;
   localparam logic [7:0] CMD_FIND_AGG    = 8'hF0;

   localparam int RES_ILLEGAL_BIT = 7;
   localparam int RES_NONE_BIT    = 6;

   typedef enum logic [2:0] {
      CK_NOP,
      CK_EN_ALL,
      CK_EN_FRIENDLY,
      CK_FIND_VIC,
      CK_FIND_AGG,
      CK_SET_EN,
      CK_ROTATE,
      CK_FLIP
   } cmd_kind_e;

   typedef enum logic [3:0] {
      S_IDLE,
      S_EN_ALL,
      S_VIC_ISSUE,
      S_VIC_WAIT,
      S_AGG_ISSUE,
      S_AGG_WAIT,
      S_EMIT,
      S_DIS_AGG,
      S_DIS_VIC,
      S_RE_FRIEND,
      S_FIN
   } state_e;

endpackage

// File: rtl/cmd_encode.sv
// Combinational mapping of a command kind plus square/value onto the
// {address, data} byte pair understood by the move-generator core.
module cmd_encode
   import chess_pkg::*;
(
   input  cmd_kind_e  kind_i,
   input  logic [5:0] sq_i,
   input  logic       val_i,
   output logic [7:0] addr_o,
   output logic [7:0] data_o
);

   always_comb begin
      addr_o = CMD_NOP;
      data_o = 8'h00;
      unique case (kind_i)
         CK_EN_ALL:      addr_o = CMD_EN_ALL;
         CK_EN_FRIENDLY: addr_o = CMD_EN_FRIENDLY;
         CK_FIND_VIC:    addr_o = CMD_FIND_VIC;
         CK_FIND_AGG: begin
            addr_o = CMD_FIND_AGG | {6'b0, sq_i[5:4]};
            data_o = {sq_i[3:0], 4'b0000};
         end
         CK_SET_EN: begin
            addr_o = CMD_SET_EN | {6'b0, sq_i[5:4]};
            data_o = {sq_i[3:0], 3'b000, val_i};
         end
         CK_ROTATE:      addr_o = CMD_ROTATE;
         CK_FLIP:        addr_o = CMD_FLIP;
         default:        addr_o = CMD_NOP;
      endcase
   end

endmodule

// File: rtl/move_enum_ctrl.sv
// MVV-LVA move enumerator driving the move-generator core's command port.
// Define MOVE_COUNT_EN to add the move_count output (accepted moves per search).
module move_enum_ctrl
   import chess_pkg::*;
#(
   parameter int unsigned RESULT_LAT = 5,
   parameter int unsigned MAX_MOVES  = 255
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       abort,
   output logic [7:0] eng_addr,
   output logic [7:0] eng_data,
   input  logic [7:0] eng_result,
   output logic       move_valid,
   input  logic       move_ready,
   output logic [5:0] move_from,
   output logic [5:0] move_to,
   output logic       busy,
   output logic       done,
   output logic       illegal
`ifdef MOVE_COUNT_EN
   ,
   output logic [7:0] move_count
`endif
);

   localparam logic [7:0] LAT_CNT = 8'(RESULT_LAT);
   localparam logic [7:0] MAX_CNT = 8'(MAX_MOVES);

   state_e     state_q;
   logic [7:0] wait_q;
   logic [7:0] emit_cnt_q;
   logic [5:0] victim_q;
   logic [5:0] aggr_q;
   logic       abort_q;
   logic [7:0] eng_addr_q;
   logic [7:0] eng_data_q;
   logic       move_valid_q;
   logic [5:0] move_from_q;
   logic [5:0] move_to_q;
   logic       busy_q;
   logic       done_q;
   logic       illegal_q;
`ifdef MOVE_COUNT_EN
   logic [7:0] move_count_q;
`endif

   cmd_kind_e  kind;
   logic [5:0] cmd_sq;
   logic [7:0] enc_addr;
   logic [7:0] enc_data;
   logic       sample;
   logic       stop_req;

   // An abort suppresses whatever command the current state would issue.
   always_comb begin
      kind   = CK_NOP;
      cmd_sq = victim_q;
      case (state_q)
         S_EN_ALL:    kind = CK_EN_ALL;
         S_VIC_ISSUE: kind = CK_FIND_VIC;
         S_AGG_ISSUE: kind = CK_FIND_AGG;
         S_DIS_AGG: begin
            kind   = CK_SET_EN;
            cmd_sq = aggr_q;
         end
         S_DIS_VIC:   kind = CK_SET_EN;
         S_RE_FRIEND: kind = CK_EN_FRIENDLY;
         default:     kind = CK_NOP;
      endcase
      if (abort) kind = CK_NOP;
   end

   cmd_encode u_enc (
      .kind_i (kind),
      .sq_i   (cmd_sq),
      .val_i  (1'b0),
      .addr_o (enc_addr),
      .data_o (enc_data)
   );

   assign sample   = (wait_q == LAT_CNT);
   assign stop_req = abort | abort_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         wait_q       <= 8'h00;
         emit_cnt_q   <= 8'h00;
         victim_q     <= 6'h00;
         aggr_q       <= 6'h00;
         abort_q      <= 1'b0;
         eng_addr_q   <= CMD_NOP;
         eng_data_q   <= 8'h00;
         move_valid_q <= 1'b0;
         move_from_q  <= 6'h00;
         move_to_q    <= 6'h00;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         illegal_q    <= 1'b0;
`ifdef MOVE_COUNT_EN
         move_count_q <= 8'h00;
`endif
      end else begin
         eng_addr_q <= enc_addr;
         eng_data_q <= enc_data;
         done_q     <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  illegal_q  <= 1'b0;
                  emit_cnt_q <= 8'h00;
                  abort_q    <= 1'b0;
                  busy_q     <= 1'b1;
                  state_q    <= S_EN_ALL;
`ifdef MOVE_COUNT_EN
                  move_count_q <= 8'h00;
`endif
               end
            end
            S_EN_ALL, S_RE_FRIEND: state_q <= abort ? S_FIN : S_VIC_ISSUE;
            S_VIC_ISSUE, S_AGG_ISSUE: begin
               wait_q  <= 8'h00;
               abort_q <= 1'b0;
               if (abort)                     state_q <= S_FIN;
               else if (state_q == S_VIC_ISSUE) state_q <= S_VIC_WAIT;
               else                           state_q <= S_AGG_WAIT;
            end
            // The core must see its result cycle through, so aborts wait here.
            S_VIC_WAIT: begin
               if (!sample) begin
                  wait_q <= wait_q + 8'd1;
                  if (abort) abort_q <= 1'b1;
               end else if (stop_req) begin
                  state_q <= S_FIN;
               end else if (eng_result[RES_ILLEGAL_BIT]) begin
                  illegal_q <= 1'b1;
                  state_q   <= S_FIN;
               end else if (eng_result[RES_NONE_BIT]) begin
                  state_q <= S_FIN;
               end else begin
                  victim_q <= eng_result[5:0];
                  state_q  <= S_AGG_ISSUE;
               end
            end
            S_AGG_WAIT: begin
               if (!sample) begin
                  wait_q <= wait_q + 8'd1;
                  if (abort) abort_q <= 1'b1;
               end else if (stop_req) begin
                  state_q <= S_FIN;
               end else if (eng_result[RES_NONE_BIT]) begin
                  state_q <= S_DIS_VIC;
               end else begin
                  aggr_q       <= eng_result[5:0];
                  move_valid_q <= 1'b1;
                  move_from_q  <= eng_result[5:0];
                  move_to_q    <= victim_q;
                  state_q      <= S_EMIT;
               end
            end
            S_EMIT: begin
               if (move_valid_q && move_ready) begin
                  move_valid_q <= 1'b0;
                  state_q      <= abort ? S_FIN : S_DIS_AGG;
`ifdef MOVE_COUNT_EN
                  if (move_count_q != 8'hFF) move_count_q <= move_count_q + 8'd1;
`endif
               end else if (abort) begin
                  move_valid_q <= 1'b0;
                  state_q      <= S_FIN;
               end
            end
            S_DIS_AGG: begin
               if (abort) begin
                  state_q <= S_FIN;
               end else begin
                  emit_cnt_q <= emit_cnt_q + 8'd1;
                  state_q    <= ((emit_cnt_q + 8'd1) == MAX_CNT) ? S_FIN : S_AGG_ISSUE;
               end
            end
            S_DIS_VIC: state_q <= abort ? S_FIN : S_RE_FRIEND;
            S_FIN: begin
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign eng_addr   = eng_addr_q;
   assign eng_data   = eng_data_q;
   assign move_valid = move_valid_q;
   assign move_from  = move_from_q;
   assign move_to    = move_to_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign illegal    = illegal_q;
`ifdef MOVE_COUNT_EN
   assign move_count = move_count_q;
`endif

endmodule

// File: tb/tb_move_enum_ctrl.sv
// Scoreboard bench for move_enum_ctrl: a scripted core model answers FIND
// commands; expected commands and moves are derived from each scenario.
module tb_move_enum_ctrl;

   localparam int RESULT_LAT = 5;
   localparam int MAX_MOVES  = 255;

   logic       clk = 1'b0;
   logic       rst, start, abort, move_ready;
   logic [7:0] eng_addr, eng_data, eng_result;
   logic       move_valid, busy, done, illegal;
   logic [5:0] move_from, move_to;
`ifdef MOVE_COUNT_EN
   logic [7:0] move_count;
`endif

   always #5 clk = ~clk;

   move_enum_ctrl #(.RESULT_LAT(RESULT_LAT), .MAX_MOVES(MAX_MOVES)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .eng_addr(eng_addr), .eng_data(eng_data), .eng_result(eng_result),
      .move_valid(move_valid), .move_ready(move_ready),
      .move_from(move_from), .move_to(move_to),
      .busy(busy), .done(done), .illegal(illegal)
`ifdef MOVE_COUNT_EN
      , .move_count(move_count)
`endif
   );

   typedef struct packed {
      logic [7:0] addr;
      logic [7:0] data;
      logic       chk_data;
   } cmd_t;

   cmd_t        exp_cmd[$];
   logic [11:0] exp_mv[$];
   logic [7:0]  core_vic_q[$];
   logic [7:0]  core_agg_q[$];
   logic [5:0]  sc_vic[$];
   int          sc_na[$];
   logic [5:0]  sc_agg[$];

   int checks = 0, errors = 0, cyc = 0, done_cnt = 0, dc_base = 0;
   int last_vic_cyc = 0, acc_cnt = 0, exp_acc = 0, force_low = 0;
   bit exp_ill, chk_lat, bp_arm, hold_low;

   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push_cmd(input logic [7:0] a, input logic [7:0] d, input logic c);
      exp_cmd.push_back('{addr: a, data: d, chk_data: c});
   endtask

   task automatic push_find_agg(input logic [5:0] s);
      push_cmd(8'hF0 + 8'(s / 16), 8'((s % 16) * 16), 1'b1);
   endtask

   task automatic push_disable(input logic [5:0] s);
      push_cmd(8'hD0 + 8'(s / 16), 8'((s % 16) * 16), 1'b1);
   endtask

   // Reference model: walk the scenario victim by victim, aggressor by aggressor.
   task automatic gen_expect(input logic [7:0] final_res);
      int k, moves;
      bit stop;
      logic [5:0] v, a;
      exp_cmd.delete(); exp_mv.delete(); core_vic_q.delete(); core_agg_q.delete();
      k = 0; moves = 0; stop = 0;
      push_cmd(8'hC0, 8'h00, 1'b0);
      push_cmd(8'hE0, 8'h00, 1'b1);
      for (int i = 0; i < sc_vic.size() && !stop; i++) begin
         v = sc_vic[i];
         core_vic_q.push_back({2'b00, v});
         push_find_agg(v);
         for (int j = 0; j < sc_na[i]; j++) begin
            a = sc_agg[k];
            k++;
            core_agg_q.push_back({1'($urandom_range(0, 1)), 1'b0, a});
            exp_mv.push_back({a, v});
            push_disable(a);
            moves++;
            if (moves == MAX_MOVES) begin
               stop = 1;
               break;
            end
            push_find_agg(v);
         end
         if (!stop) begin
            core_agg_q.push_back(8'h40 | 8'($urandom_range(0, 1) << 7) | 8'($urandom_range(0, 63)));
            push_disable(v);
            push_cmd(8'h80, 8'h00, 1'b0);
            push_cmd(8'hE0, 8'h00, 1'b1);
         end
      end
      if (!stop) core_vic_q.push_back(final_res);
      exp_ill = !stop && final_res[7];
      chk_lat = !stop;
      exp_acc = moves;
   endtask

   task automatic build(input int nv, input bit big, input bit ill);
      int n;
      sc_vic.delete(); sc_na.delete(); sc_agg.delete();
      for (int i = 0; i < nv; i++) begin
         sc_vic.push_back(6'($urandom));
         n = big ? 300 : $urandom_range(0, 3);
         sc_na.push_back(n);
         for (int j = 0; j < n; j++) sc_agg.push_back(6'($urandom));
      end
      gen_expect(ill ? 8'(8'h80 | $urandom_range(0, 127)) : 8'(8'h40 | $urandom_range(0, 63)));
   endtask

   task automatic build_single();
      sc_vic.delete(); sc_na.delete(); sc_agg.delete();
      sc_vic.push_back(6'h1C); sc_na.push_back(1); sc_agg.push_back(6'h14);
      gen_expect(8'h40);
   endtask

   task automatic kick();
      dc_base = done_cnt;
      @(posedge clk); #2 start = 1'b1;
      @(posedge clk); #2 start = 1'b0;
   endtask

   task automatic finish_search(input string tag);
      int i;
      for (i = 0; i < 20000 && done_cnt == dc_base; i++) @(posedge clk);
      if (done_cnt == dc_base) begin
         checks++; errors++;
         $display("FAIL %s_timeout actual=no-done required=done", tag);
      end
      repeat (3) @(posedge clk);
      #2;
      check({tag, "_cmds_left"}, exp_cmd.size(), 0);
      check({tag, "_moves_left"}, exp_mv.size(), 0);
      check({tag, "_done_pulses"}, done_cnt - dc_base, 1);
      check({tag, "_illegal"}, illegal, exp_ill);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_valid"}, move_valid, 0);
`ifdef MOVE_COUNT_EN
      check({tag, "_move_count"}, move_count, exp_acc);
`endif
   endtask

   // Core model: result valid only in cycle n+RESULT_LAT, random noise otherwise.
   initial begin
      int pend;
      logic [7:0] pr;
      pend = 0; pr = 8'h00; eng_result = 8'h00;
      forever begin
         @(posedge clk); #1;
         if (rst) begin
            pend = 0;
            eng_result = 8'($urandom);
         end else begin
            if (pend > 0 && eng_addr != 8'h00) check("cmd_during_wait", eng_addr, 0);
            if (eng_addr == 8'hE0) begin
               pr = (core_vic_q.size() > 0) ? core_vic_q.pop_front() : 8'h40;
               pend = RESULT_LAT;
               eng_result = 8'($urandom);
            end else if (eng_addr[7:4] == 4'hF) begin
               pr = (core_agg_q.size() > 0) ? core_agg_q.pop_front() : 8'hC0;
               pend = RESULT_LAT;
               eng_result = 8'($urandom);
            end else if (pend > 0) begin
               pend--;
               eng_result = (pend == 0) ? pr : 8'($urandom);
            end else begin
               eng_result = 8'($urandom);
            end
         end
      end
   end

   initial begin
      move_ready = 1'b0;
      forever begin
         @(posedge clk); #1;
         if (bp_arm && move_valid) begin
            force_low = 10;
            bp_arm = 0;
         end
         if (hold_low) move_ready = 1'b0;
         else if (force_low > 0) begin
            move_ready = 1'b0;
            force_low--;
         end else move_ready = ($urandom_range(0, 3) != 0);
      end
   end

   // Monitor: pops expectations whenever the DUT presents a command, move or done.
   initial begin
      cmd_t c;
      bit mv_hold, prev_hs;
      logic [11:0] hold_ft;
      mv_hold = 0; prev_hs = 0; hold_ft = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            mv_hold = 0;
            prev_hs = 0;
         end else begin
            if (eng_addr != 8'h00) begin
               if (eng_addr == 8'hE0) last_vic_cyc = cyc;
               if (exp_cmd.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL unexpected_cmd actual=%0h/%0h required=no-op", eng_addr, eng_data);
               end else begin
                  c = exp_cmd.pop_front();
                  check("cmd_addr", eng_addr, c.addr);
                  if (c.chk_data) check("cmd_data", eng_data, c.data);
               end
            end
            if (prev_hs) check("valid_after_accept", move_valid, 0);
            if (mv_hold) begin
               check("bp_valid_held", move_valid, 1);
               check("bp_from_to_held", {move_from, move_to}, hold_ft);
            end
            if (move_valid && move_ready) begin
               acc_cnt++;
               if (exp_mv.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL unexpected_move actual=%0d->%0d required=none", move_from, move_to);
               end else check("move_from_to", {move_from, move_to}, exp_mv.pop_front());
            end
            prev_hs = move_valid && move_ready;
            mv_hold = move_valid && !move_ready && !abort;
            hold_ft = {move_from, move_to};
            if (done) begin
               done_cnt++;
               if (chk_lat) check("done_latency", cyc - last_vic_cyc, RESULT_LAT + 2);
            end
         end
      end
   end

   initial begin
      int i;
      rst = 1'b1; start = 1'b0; abort = 1'b0;
      hold_low = 0; bp_arm = 0;
      #3;
      check("rst_addr", eng_addr, 0);
      check("rst_data", eng_data, 0);
      check("rst_valid", move_valid, 0);
      check("rst_from_to", {move_from, move_to}, 0);
      check("rst_busy_done_ill", {busy, done, illegal}, 0);
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;

      build(0, 0, 0); kick(); finish_search("no_victim");
      build_single(); kick(); finish_search("single");
      build(0, 0, 1); core_vic_q[0] = 8'h9C; kick(); finish_search("illegal");
      build_single(); bp_arm = 1; kick(); finish_search("backpressure");
      for (int s = 0; s < 8; s++) begin
         build($urandom_range(0, 4), 0, 1'($urandom_range(0, 1)));
         kick(); finish_search("random");
      end

      // Abort in the second cycle of the victim wait.
      build(2, 0, 0);
      exp_cmd.delete(); exp_mv.delete();
      push_cmd(8'hC0, 8'h00, 1'b0); push_cmd(8'hE0, 8'h00, 1'b1);
      exp_ill = 0; chk_lat = 1; exp_acc = 0;
      kick();
      for (i = 0; i < 50 && eng_addr != 8'hE0; i++) begin
         @(posedge clk); #2;
      end
      @(posedge clk); #2 abort = 1'b1;
      @(posedge clk); #2 abort = 1'b0;
      finish_search("abort_vic");

      // Abort while a move is being offered and not accepted.
      build_single();
      exp_cmd.delete(); exp_mv.delete();
      push_cmd(8'hC0, 8'h00, 1'b0); push_cmd(8'hE0, 8'h00, 1'b1); push_find_agg(6'h1C);
      exp_ill = 0; chk_lat = 0; exp_acc = 0;
      hold_low = 1;
      kick();
      for (i = 0; i < 100 && !move_valid; i++) begin
         @(posedge clk); #2;
      end
      abort = 1'b1;
      @(posedge clk); #2 abort = 1'b0;
      finish_search("abort_emit");
      hold_low = 0;

      build(2, 1, 0); kick(); finish_search("max_moves");

      // Reset during an aggressor wait, then a normal search.
      build(1, 0, 0);
      kick();
      for (i = 0; i < 100 && eng_addr[7:4] != 4'hF; i++) begin
         @(posedge clk); #2;
      end
      @(posedge clk); #2;
      @(posedge clk); #3 rst = 1'b1;
      #1;
      check("midrst_addr", eng_addr, 0);
      check("midrst_data", eng_data, 0);
      check("midrst_valid", move_valid, 0);
      check("midrst_from_to", {move_from, move_to}, 0);
      check("midrst_busy", busy, 0);
      check("midrst_done_ill", {done, illegal}, 0);
      @(posedge clk); #2 rst = 1'b0;
      build(3, 0, 0); kick(); finish_search("after_reset");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
